plru_repl_ctrl: RTL and testbench

- Replacement controller placed in front of one 4-way tree-PLRU state array (PLRU4-style instance) in an L1 cache.
- Merges hit-update traffic from two load/store hit ports into the array's single read-update port.
- Runs the refill victim-allocation sequence (lookup, allocate, respond) on the write-update port.
- Guarantees that a read-update and a write-update never target the same set in the same cycle, so no update is silently dropped.

---
 rtl/plru_pkg.sv | 34 +++
 rtl/plru_hit_fifo.sv | 57 +++++
 rtl/plru_repl_ctrl.sv | 150 +++++++++++++++
 tb/tb_plru_repl_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/plru_pkg.sv
// plru_pkg: types and constants shared by the PLRU replacement controller.
// Covers the FSM state encoding, the hit-queue entry and the way width.
package plru_pkg;

    localparam int WAYS   = 4;
    localparam int WW     = $clog2(WAYS);
    localparam int SW_MAX = 16;

    typedef logic [WW-1:0] way_t;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        ALLOC,
        RESP
    } repl_state_e;

    // Set field sized for the largest array; unused upper bits stay zero.
    typedef struct packed {
        logic [SW_MAX-1:0] set;
        way_t              way;
    } hit_t;

    function automatic hit_t mk_hit(
        input logic [SW_MAX-1:0] set,
        input way_t              way
    );
        hit_t h;
        h.set = set;
        h.way = way;
        return h;
    endfunction

endpackage

// File: rtl/plru_hit_fifo.sv
// plru_hit_fifo: 2-write / 1-read FIFO of pending PLRU hit updates.
// Port 0 is written ahead of port 1 when both write in one cycle.
module plru_hit_fifo
    import plru_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr0_en,
    input  hit_t        wr0_data,
    input  logic        wr1_en,
    input  hit_t        wr1_data,
    input  logic        rd_en,
    output hit_t        rd_data,
    output logic [AW:0] count
);

    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW:0]   n_wr;
    logic [AW-1:0] widx0;
    logic [AW-1:0] widx1;
    hit_t          first;
    hit_t          mem [DEPTH];

    assign widx0   = wptr[AW-1:0];
    assign widx1   = widx0 + AW'(1);
    assign first   = wr0_en ? wr0_data : wr1_data;
    assign n_wr    = (AW+1)'(wr0_en) + (AW+1)'(wr1_en);
    assign count   = wptr - rptr;
    assign rd_data = mem[rptr[AW-1:0]];

    // Storage and pointers; the first written slot always gets the older entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr0_en || wr1_en) begin
                mem[widx0] <= first;
            end
            if (wr0_en && wr1_en) begin
                mem[widx1] <= wr1_data;
            end
            wptr <= wptr + n_wr;
            if (rd_en) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/plru_repl_ctrl.sv
// plru_repl_ctrl: merges two hit ports onto the PLRU read-update port and
// runs refill victim allocation on the write-update port without set clashes.
module plru_repl_ctrl
    import plru_pkg::*;
#(
    parameter  int SETS     = 256,
    parameter  int HQ_DEPTH = 4,
    localparam int SW       = $clog2(SETS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          repl_en,
    input  logic          hitA_valid,
    output logic          hitA_ready,
    input  logic [SW-1:0] hitA_set,
    input  logic [WW-1:0] hitA_way,
    input  logic          hitB_valid,
    output logic          hitB_ready,
    input  logic [SW-1:0] hitB_set,
    input  logic [WW-1:0] hitB_way,
    input  logic          alloc_valid,
    output logic          alloc_ready,
    input  logic [SW-1:0] alloc_set,
    output logic          victim_valid,
    output logic [WW-1:0] victim_way,
    input  logic          victim_ready,
    output logic          plru_update_en,
    output logic [SW-1:0] plru_read_set,
    output logic [WW-1:0] plru_read_way,
    output logic          plru_read_access,
    output logic [SW-1:0] plru_write_set,
    output logic [WW-1:0] plru_write_way,
    output logic          plru_write_access,
    input  logic [WW-1:0] plru_lru_way
);

    localparam int CW = $clog2(HQ_DEPTH) + 1;

    localparam logic [CW:0] DEPTH_W = (CW+1)'(HQ_DEPTH);
    localparam logic [CW:0] ONE_W   = (CW+1)'(1);
    localparam logic [CW:0] TWO_W   = (CW+1)'(2);

    repl_state_e   state;
    logic [SW-1:0] set_r;
    way_t          vic_r;
    logic          wr_acc_r;
    logic          vic_valid_r;

    logic [CW-1:0] hq_count;
    hit_t          head;
    hit_t          hit_a;
    hit_t          hit_b;
    logic          hq_empty;
    logic          conflict;
    logic          deq;
    logic [CW:0]   free;
    logic          acc_a;
    logic          acc_b;

    assign hit_a = mk_hit(SW_MAX'(hitA_set), hitA_way);
    assign hit_b = mk_hit(SW_MAX'(hitB_set), hitB_way);

    plru_hit_fifo #(
        .DEPTH (HQ_DEPTH)
    ) u_hit_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr0_en   (acc_a),
        .wr0_data (hit_a),
        .wr1_en   (acc_b),
        .wr1_data (hit_b),
        .rd_en    (deq),
        .rd_data  (head),
        .count    (hq_count)
    );

    // Only the ALLOC write can clash with a queued hit to the same set.
    assign hq_empty = (hq_count == '0);
    assign conflict = (state == ALLOC) && (head.set == SW_MAX'(set_r));
    assign deq      = !hq_empty && !conflict;

    // Free slots include the entry draining this cycle.
    assign free = DEPTH_W - {1'b0, hq_count} + (CW+1)'(deq);

    // Hit-port handshakes; port A takes priority on the last free slot.
    always_comb begin
        hitA_ready = 1'b0;
        hitB_ready = 1'b0;
        if (!rst) begin
            hitA_ready = (free >= ONE_W);
            hitB_ready = (free >= TWO_W) ||
                         ((free >= ONE_W) && !hitA_valid);
        end
    end

    assign acc_a = hitA_valid && hitA_ready;
    assign acc_b = hitB_valid && hitB_ready;

    assign plru_update_en   = repl_en;
    assign plru_read_access = deq;
    assign plru_read_set    = head.set[SW-1:0];
    assign plru_read_way    = head.way;

    assign alloc_ready       = !rst && (state == IDLE);
    assign plru_write_set    = set_r;
    assign plru_write_way    = vic_r;
    assign plru_write_access = wr_acc_r;
    assign victim_valid      = vic_valid_r;
    assign victim_way        = vic_r;

    // Allocation sequence: look up LRU, touch it on the write port, hand it out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            set_r       <= '0;
            vic_r       <= '0;
            wr_acc_r    <= 1'b0;
            vic_valid_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (alloc_valid) begin
                        set_r <= alloc_set;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    vic_r    <= plru_lru_way;
                    wr_acc_r <= 1'b1;
                    state    <= ALLOC;
                end
                ALLOC: begin
                    wr_acc_r    <= 1'b0;
                    vic_valid_r <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (victim_ready) begin
                        vic_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plru_repl_ctrl.sv
// tb_plru_repl_ctrl: directed checks of hit merging, allocation and reset.
// Expected values are hand-derived cycle by cycle.
module tb_plru_repl_ctrl;

    logic       clk;
    logic       rst;
    logic       repl_en;
    logic       hitA_valid;
    logic       hitA_ready;
    logic [7:0] hitA_set;
    logic [1:0] hitA_way;
    logic       hitB_valid;
    logic       hitB_ready;
    logic [7:0] hitB_set;
    logic [1:0] hitB_way;
    logic       alloc_valid;
    logic       alloc_ready;
    logic [7:0] alloc_set;
    logic       victim_valid;
    logic [1:0] victim_way;
    logic       victim_ready;
    logic       plru_update_en;
    logic [7:0] plru_read_set;
    logic [1:0] plru_read_way;
    logic       plru_read_access;
    logic [7:0] plru_write_set;
    logic [1:0] plru_write_way;
    logic       plru_write_access;
    logic [1:0] lru;

    int checks;
    int errors;

    plru_repl_ctrl #(
        .SETS     (256),
        .HQ_DEPTH (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .repl_en           (repl_en),
        .hitA_valid        (hitA_valid),
        .hitA_ready        (hitA_ready),
        .hitA_set          (hitA_set),
        .hitA_way          (hitA_way),
        .hitB_valid        (hitB_valid),
        .hitB_ready        (hitB_ready),
        .hitB_set          (hitB_set),
        .hitB_way          (hitB_way),
        .alloc_valid       (alloc_valid),
        .alloc_ready       (alloc_ready),
        .alloc_set         (alloc_set),
        .victim_valid      (victim_valid),
        .victim_way        (victim_way),
        .victim_ready      (victim_ready),
        .plru_update_en    (plru_update_en),
        .plru_read_set     (plru_read_set),
        .plru_read_way     (plru_read_way),
        .plru_read_access  (plru_read_access),
        .plru_write_set    (plru_write_set),
        .plru_write_way    (plru_write_way),
        .plru_write_access (plru_write_access),
        .plru_lru_way      (lru)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hits(input logic av, input logic [7:0] as,
                        input logic [1:0] aw, input logic bv,
                        input logic [7:0] bs, input logic [1:0] bw);
        hitA_valid = av;
        hitA_set   = as;
        hitA_way   = aw;
        hitB_valid = bv;
        hitB_set   = bs;
        hitB_way   = bw;
    endtask

    task automatic chk_rd(input string tag, input logic [7:0] s,
                          input logic [1:0] w);
        chk({tag, "_acc"}, 32'(plru_read_access), 32'd1);
        chk({tag, "_set"}, 32'(plru_read_set), 32'(s));
        chk({tag, "_way"}, 32'(plru_read_way), 32'(w));
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        repl_en      = 1'b0;
        alloc_valid  = 1'b0;
        alloc_set    = '0;
        victim_ready = 1'b0;
        lru          = '0;
        hits(0, 0, 0, 0, 0, 0);

        // Reset held three cycles, then idle.
        repeat (3) tick();
        chk("rst_outs", 32'({hitA_ready, hitB_ready, alloc_ready,
            victim_valid, victim_way, plru_update_en, plru_read_set,
            plru_read_way, plru_read_access, plru_write_set,
            plru_write_way, plru_write_access}), 32'd0);
        rst     = 1'b0;
        repl_en = 1'b1;
        #1;
        chk("idle_alloc_rdy", 32'(alloc_ready), 32'd1);
        chk("idle_a_rdy", 32'(hitA_ready), 32'd1);
        chk("idle_b_rdy", 32'(hitB_ready), 32'd1);
        chk("idle_rd_acc", 32'(plru_read_access), 32'd0);
        chk("upd_en", 32'(plru_update_en), 32'd1);

        // Dual hit: A ahead of B.
        tick();
        hits(1, 8'd5, 2'd2, 1, 8'd9, 2'd1);
        #1;
        chk("dual_b_rdy", 32'(hitB_ready), 32'd1);
        tick();
        hits(0, 0, 0, 0, 0, 0);
        #1;
        chk_rd("dual_first", 8'd5, 2'd2);
        tick();
        chk_rd("dual_second", 8'd9, 2'd1);
        tick();
        chk("dual_empty", 32'(plru_read_access), 32'd0);

        // Allocation of set 7 with LRU way 3.
        alloc_valid = 1'b1;
        alloc_set   = 8'd7;
        lru         = 2'd3;
        #1;
        chk("al_rdy", 32'(alloc_ready), 32'd1);
        tick();
        alloc_valid = 1'b0;
        #1;
        chk("al_lk_set", 32'(plru_write_set), 32'd7);
        chk("al_lk_acc", 32'(plru_write_access), 32'd0);
        chk("al_lk_rdy", 32'(alloc_ready), 32'd0);
        tick();
        chk("al_wr_acc", 32'(plru_write_access), 32'd1);
        chk("al_wr_set", 32'(plru_write_set), 32'd7);
        chk("al_wr_way", 32'(plru_write_way), 32'd3);
        chk("al_wr_vv", 32'(victim_valid), 32'd0);
        tick();
        lru = 2'd0;
        #1;
        chk("al_vv", 32'(victim_valid), 32'd1);
        chk("al_vway", 32'(victim_way), 32'd3);
        chk("al_resp_wacc", 32'(plru_write_access), 32'd0);
        tick();
        chk("al_hold_vv", 32'(victim_valid), 32'd1);
        chk("al_hold_vway", 32'(victim_way), 32'd3);
        victim_ready = 1'b1;
        tick();
        victim_ready = 1'b0;
        #1;
        chk("al_done_vv", 32'(victim_valid), 32'd0);
        chk("al_done_rdy", 32'(alloc_ready), 32'd1);

        // Same-set conflict: head {7,0} during ALLOC of set 7.
        alloc_valid = 1'b1;
        alloc_set   = 8'd7;
        lru         = 2'd1;
        tick();
        alloc_valid = 1'b0;
        hits(1, 8'd7, 2'd0, 0, 0, 0);
        tick();
        hits(0, 0, 0, 0, 0, 0);
        #1;
        chk("cf_stall", 32'(plru_read_access), 32'd0);
        chk("cf_wacc", 32'(plru_write_access), 32'd1);
        chk("cf_wway", 32'(plru_write_way), 32'd1);
        tick();
        chk_rd("cf_release", 8'd7, 2'd0);
        chk("cf_vv", 32'(victim_valid), 32'd1);
        victim_ready = 1'b1;
        tick();
        victim_ready = 1'b0;
        #1;
        chk("cf_empty", 32'(plru_read_access), 32'd0);

        // Queue fill while ALLOC of set 3 stalls the head.
        hits(1, 8'd3, 2'd0, 1, 8'd3, 2'd1);
        tick();
        hits(1, 8'd3, 2'd2, 1, 8'd3, 2'd3);
        alloc_valid = 1'b1;
        alloc_set   = 8'd3;
        lru         = 2'd2;
        #1;
        chk_rd("qf_c0", 8'd3, 2'd0);
        chk("qf_c0_brdy", 32'(hitB_ready), 32'd1);
        tick();
        alloc_valid = 1'b0;
        hits(1, 8'd4, 2'd1, 1, 8'd5, 2'd2);
        #1;
        chk_rd("qf_c1", 8'd3, 2'd1);
        chk("qf_c1_brdy", 32'(hitB_ready), 32'd1);
        tick();
        hits(1, 8'd6, 2'd3, 1, 8'd6, 2'd0);
        #1;
        chk("qf_stall", 32'(plru_read_access), 32'd0);
        chk("qf_full_a", 32'(hitA_ready), 32'd0);
        chk("qf_full_b", 32'(hitB_ready), 32'd0);
        tick();
        hits(0, 0, 0, 0, 0, 0);
        victim_ready = 1'b1;
        #1;
        chk_rd("qf_d0", 8'd3, 2'd2);
        tick();
        victim_ready = 1'b0;
        #1;
        chk_rd("qf_d1", 8'd3, 2'd3);
        tick();
        chk_rd("qf_d2", 8'd4, 2'd1);
        tick();
        chk_rd("qf_d3", 8'd5, 2'd2);
        tick();
        chk("qf_empty", 32'(plru_read_access), 32'd0);

        // Reset asserted mid-cycle while in RESP with hits queued.
        alloc_valid = 1'b1;
        alloc_set   = 8'd10;
        lru         = 2'd2;
        tick();
        alloc_valid = 1'b0;
        tick();
        hits(1, 8'd1, 2'd1, 1, 8'd2, 2'd2);
        tick();
        hits(0, 0, 0, 0, 0, 0);
        #1;
        chk("mr_vv", 32'(victim_valid), 32'd1);
        chk("mr_vway", 32'(victim_way), 32'd2);
        chk_rd("mr_head", 8'd1, 2'd1);
        rst = 1'b1;
        #1;
        chk("mr_async_vv", 32'(victim_valid), 32'd0);
        chk("mr_async_racc", 32'(plru_read_access), 32'd0);
        chk("mr_async_ardy", 32'(alloc_ready), 32'd0);
        chk("mr_async_hrdy", 32'(hitA_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mr_post_ardy", 32'(alloc_ready), 32'd1);
        chk("mr_post_racc", 32'(plru_read_access), 32'd0);
        chk("mr_post_vv", 32'(victim_valid), 32'd0);
        chk("mr_post_wacc", 32'(plru_write_access), 32'd0);
        tick();
        chk("mr_still_empty", 32'(plru_read_access), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
